// File: rtl/uart_err_pkg.sv
// uart_err_pkg: shared widths and flag struct for the UART error manager
package uart_err_pkg;
  localparam int BRK_CNT_W = 8;
  localparam int TO_CNT_W = 8;
  localparam int ACC_W = 33;
  typedef struct packed {
    logic framing;
    logic parity;
    logic brk;
    logic timeout;
  } err_flags_t;
endpackage

// File: rtl/uart_error_manager_if.sv
// uart_error_manager_if: RX-side status inputs and sticky error outputs
interface uart_error_manager_if;
  logic        frame_error;
  logic        parity_error;
  logic        frame_active;
  logic        bit_valid;
  logic        rx_filtered;
  logic [31:0] baud_rate;
  logic        error_clear;
  logic        error_detected;
  logic        framing_error;
  logic        parity_err;
  logic        break_detect;
  logic        timeout_detect;
  modport master (
    output frame_error, parity_error, frame_active, bit_valid, rx_filtered, baud_rate, error_clear,
    input  error_detected, framing_error, parity_err, break_detect, timeout_detect
  );
  modport slave (
    input  frame_error, parity_error, frame_active, bit_valid, rx_filtered, baud_rate, error_clear,
    output error_detected, framing_error, parity_err, break_detect, timeout_detect
  );
endinterface

// File: rtl/uart_bit_period_tick.sv
// uart_bit_period_tick: fractional baud accumulator pulsing once per bit period while en
module uart_bit_period_tick
  import uart_err_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ_HZ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] baud_rate,
  output logic        tick
);
  localparam logic [ACC_W-1:0] LIM = ACC_W'(CLK_FREQ_HZ);
  logic [ACC_W-1:0] acc_q, acc_d, sum, rem;
  // remainder still above the limit means baud >= clock; that excess is dropped
  always_comb begin
    sum = acc_q + ACC_W'(baud_rate);
    rem = sum - LIM;
    tick = en && sum >= LIM;
    acc_d = !en ? '0 : !tick ? sum : rem >= LIM ? '0 : rem;
  end
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else acc_q <= acc_d;
  end
endmodule

// File: rtl/uart_error_manager.sv
// uart_error_manager: sticky framing/parity/break/timeout flags; break logic under UART_ERR_BREAK_DETECT_EN
module uart_error_manager
  import uart_err_pkg::*;
#(
  parameter logic [31:0] CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned TIMEOUT_BIT_PERIODS = 3,
  parameter int unsigned BREAK_BITS = 10
) (
  input logic clk,
  input logic rst,
  uart_error_manager_if.slave bus
);
  err_flags_t flags_q, flags_d, set;
  logic err_q, err_d, armed_q, armed_d, tick, idle_en, to_fire, brk_set;
  logic [TO_CNT_W-1:0] idle_q, idle_d;
  uart_bit_period_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(idle_en),
    .baud_rate(bus.baud_rate),
    .tick(tick)
  );
`ifdef UART_ERR_BREAK_DETECT_EN
  logic [BRK_CNT_W-1:0] brk_q, brk_d;
  logic brk_inc;
  always_comb begin
    brk_inc = bus.bit_valid && bus.frame_active && !bus.rx_filtered && brk_q != '1;
    brk_set = brk_inc && (brk_q + 1'b1) == BRK_CNT_W'(BREAK_BITS);
    brk_d = (!bus.frame_active || (bus.bit_valid && bus.rx_filtered) || bus.error_clear) ? '0 :
            brk_inc ? brk_q + 1'b1 : brk_q;
  end
  always_ff @(posedge clk) begin
    if (rst) brk_q <= '0;
    else brk_q <= brk_d;
  end
`else
  assign brk_set = 1'b0;
`endif
  always_comb begin
    idle_en = armed_q && !bus.frame_active && bus.rx_filtered;
    to_fire = tick && (idle_q + 1'b1) == TO_CNT_W'(TIMEOUT_BIT_PERIODS);
    idle_d = (!idle_en || to_fire) ? '0 : tick ? idle_q + 1'b1 : idle_q;
    armed_d = (armed_q || bus.frame_active) && !to_fire;
    set = '{framing: bus.frame_error, parity: bus.parity_error, brk: brk_set, timeout: to_fire};
    flags_d = set | (bus.error_clear ? '0 : flags_q);
    err_d = flags_d.framing | flags_d.parity | flags_d.brk;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
      err_q <= 1'b0;
      armed_q <= 1'b0;
      idle_q <= '0;
    end else begin
      flags_q <= flags_d;
      err_q <= err_d;
      armed_q <= armed_d;
      idle_q <= idle_d;
    end
  end
  assign bus.error_detected = err_q;
  assign bus.framing_error = flags_q.framing;
  assign bus.parity_err = flags_q.parity;
  assign bus.break_detect = flags_q.brk;
  assign bus.timeout_detect = flags_q.timeout;
endmodule

// File: tb/tb_uart_error_manager.sv
// tb_uart_error_manager: scoreboard bench; output vector is {error_detected, framing, parity, break, timeout}
module tb_uart_error_manager;
`ifdef UART_ERR_BREAK_DETECT_EN
  localparam bit BRK_EN = 1'b1;
`else
  localparam bit BRK_EN = 1'b0;
`endif
  typedef struct {
    string      tag;
    logic [4:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  uart_error_manager_if bus();
  uart_error_manager dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [4:0] obs();
    return {bus.error_detected, bus.framing_error, bus.parity_err, bus.break_detect, bus.timeout_detect};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic expect_out(input string tag, input logic [4:0] v);
    exp_q.push_back('{tag: tag, v: v});
  endtask
  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    e = exp_q.pop_front();
    check(e.tag, 32'(obs()), 32'(e.v));
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic strobe(input int n);
    repeat (n) begin
      bus.bit_valid = 1'b1;
      step();
      bus.bit_valid = 1'b0;
      step(9);
    end
  endtask
  task automatic clear();
    bus.error_clear = 1'b1;
    step();
    bus.error_clear = 1'b0;
  endtask
  initial begin
    int n;
    bus.frame_error = 0; bus.parity_error = 0; bus.frame_active = 0; bus.bit_valid = 0;
    bus.rx_filtered = 1; bus.baud_rate = 0; bus.error_clear = 0;
    step(2);
    expect_out("reset", 5'b00000); compare_out();
    rst = 1'b0;
    bus.frame_active = 1; bus.frame_error = 1;
    step();
    bus.frame_error = 0; bus.frame_active = 0;
    expect_out("frame_set", 5'b11000); compare_out();
    step(5);
    expect_out("frame_hold", 5'b11000); compare_out();
    clear();
    expect_out("clear1", 5'b00000); compare_out();
    bus.parity_error = 1;
    step();
    bus.parity_error = 0;
    expect_out("parity_set", 5'b10100); compare_out();
    bus.frame_error = 1; bus.parity_error = 1;
    step();
    bus.frame_error = 0; bus.parity_error = 0;
    expect_out("both_set", 5'b11100); compare_out();
    clear();
    expect_out("both_clr", 5'b00000); compare_out();
    bus.error_clear = 1; bus.parity_error = 1;
    step();
    bus.error_clear = 0; bus.parity_error = 0;
    expect_out("set_wins", 5'b10100); compare_out();
    clear();
    bus.frame_active = 1; bus.rx_filtered = 0;
    strobe(9);
    expect_out("brk_9", 5'b00000); compare_out();
    strobe(1);
    expect_out("brk_10", {BRK_EN, 2'b00, BRK_EN, 1'b0}); compare_out();
    clear();
    strobe(9);
    bus.rx_filtered = 1;
    strobe(1);
    bus.rx_filtered = 0;
    strobe(5);
    expect_out("brk_rx_reset", 5'b00000); compare_out();
    bus.error_clear = 1; bus.rx_filtered = 1;
    step();
    bus.error_clear = 0; bus.frame_active = 0; bus.baud_rate = 9600;
    step(31000);
    expect_out("to_31000", 5'b00000); compare_out();
    n = 31000;
    while (!bus.timeout_detect && n < 32000) begin
      step();
      n++;
    end
    expect_out("to_fire", 5'b00001); compare_out();
    check("to_cycles", 32'(n >= 31249 && n <= 31251), 1);
    bus.baud_rate = 1_000_000;
    clear();
    step(1000);
    expect_out("to_once", 5'b00000); compare_out();
    bus.frame_active = 1;
    step();
    bus.frame_active = 0; bus.baud_rate = 200_000_000;
    step(2);
    expect_out("fast_2", 5'b00000); compare_out();
    step();
    expect_out("fast_3", 5'b00001); compare_out();
    bus.frame_active = 1; bus.error_clear = 1;
    step();
    bus.frame_active = 0; bus.error_clear = 0; bus.baud_rate = 0;
    step(2000);
    expect_out("baud0", 5'b00000); compare_out();
    bus.frame_error = 1; bus.frame_active = 1;
    step();
    bus.frame_error = 0; bus.frame_active = 0; bus.baud_rate = 1_000_000;
    step(150);
    rst = 1;
    step();
    rst = 0;
    expect_out("rst_mid_to", 5'b00000); compare_out();
    step(1000);
    expect_out("rst_no_to", 5'b00000); compare_out();
    bus.baud_rate = 0; bus.frame_active = 1; bus.rx_filtered = 0;
    strobe(5);
    rst = 1;
    step();
    rst = 0;
    strobe(5);
    expect_out("rst_mid_brk", 5'b00000); compare_out();
    strobe(5);
    expect_out("brk_after_rst", {BRK_EN, 2'b00, BRK_EN, 1'b0}); compare_out();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
